// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed 7-seg scanner with blanking gap and frame-synchronous double buffer; SEG7_DIM_EN adds bright[1:0] dimming
module seg7_scan_driver #(
  parameter int PRESCALE = 50000,
  parameter int GAP = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [6:0] digit1,
  input  logic [6:0] digit2,
  input  logic [6:0] digit3,
  input  logic [6:0] digit4,
`ifdef SEG7_DIM_EN
  input  logic [1:0] bright,
`endif
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_done,
  output logic       pending
);
  localparam int MX = PRESCALE > GAP ? PRESCALE : GAP;
  localparam int CW = $clog2(MX);
  typedef enum logic [1:0] {S_IDLE, S_GAP, S_ON} state_t;
  state_t state, state_n;
  logic [1:0] idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [6:0] act [4];
  logic [6:0] act_n [4];
  logic [6:0] shd [4];
  logic [6:0] shd_n [4];
  logic [6:0] dig [4];
  logic pend_n, last_on, wrap, lit, fd_n;
  logic [3:0] an_n;
  logic [6:0] seg_n;
`ifdef SEG7_DIM_EN
  logic [1:0] br, br_n;
`endif
  assign dig = '{digit1, digit2, digit3, digit4};
  // state, buffers and registered outputs; outputs are derived from next-state values so they align with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx <= '0;
      cnt <= '0;
      act <= '{default: 7'h7F};
      shd <= '{default: 7'h7F};
      pending <= 1'b0;
      an <= 4'hF;
      seg <= 7'h7F;
      frame_done <= 1'b0;
`ifdef SEG7_DIM_EN
      br <= 2'd3;
`endif
    end else begin
      state <= state_n;
      idx <= idx_n;
      cnt <= cnt_n;
      act <= act_n;
      shd <= shd_n;
      pending <= pend_n;
      an <= an_n;
      seg <= seg_n;
      frame_done <= fd_n;
`ifdef SEG7_DIM_EN
      br <= br_n;
`endif
    end
  end
  // next state: scan sequencing plus shadow/active buffer update at frame boundary
  always_comb begin
    state_n = state;
    idx_n = idx;
    cnt_n = cnt;
    last_on = cnt == CW'(PRESCALE - 1);
    wrap = en && state == S_ON && last_on && idx == 2'd3;
    if (!en) begin
      state_n = S_IDLE;
      idx_n = '0;
      cnt_n = '0;
    end else if (state == S_IDLE) begin
      state_n = GAP == 0 ? S_ON : S_GAP;
      idx_n = '0;
      cnt_n = '0;
    end else if (state == S_GAP) begin
      state_n = cnt == CW'(GAP - 1) ? S_ON : S_GAP;
      cnt_n = cnt == CW'(GAP - 1) ? '0 : cnt + 1'b1;
    end else begin
      state_n = !last_on || GAP == 0 ? S_ON : S_GAP;
      cnt_n = last_on ? '0 : cnt + 1'b1;
      idx_n = last_on ? idx + 1'b1 : idx;
    end
    act_n = act;
    shd_n = shd;
    pend_n = pending;
    if (load && state == S_IDLE) begin
      act_n = dig;
      pend_n = 1'b0;
    end else if (wrap) begin
      if (load) act_n = dig;
      else if (pending) act_n = shd;
      pend_n = 1'b0;
    end else if (load) begin
      shd_n = dig;
      pend_n = 1'b1;
    end
  end
  // outputs for the upcoming cycle: one anode in ON, brightness gating of the cathodes
  always_comb begin
`ifdef SEG7_DIM_EN
    br_n = state_n == S_ON && cnt_n == '0 ? bright : br;
    lit = int'(cnt_n) < (int'(br_n) + 1) * (PRESCALE / 4);
`else
    lit = 1'b1;
`endif
    an_n = state_n == S_ON ? ~(4'b1000 >> idx_n) : 4'hF;
    seg_n = state_n == S_ON && lit ? act_n[idx_n] : 7'h7F;
    fd_n = state_n == S_ON && idx_n == 2'd3 && cnt_n == CW'(PRESCALE - 1);
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized and directed checks of seg7_scan_driver against a frame-position model
module tb_seg7_scan_driver;
  localparam int P = 8;
  localparam int G = 2;
  localparam int S = P + G;
  localparam int FR = 4 * S;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, load = 1'b0;
  logic [6:0] dg [4];
  logic [1:0] bright = 2'd3;
  logic [6:0] seg;
  logic [3:0] an;
  logic frame_done, pending;
  int checks = 0, passed = 0;
  bit m_run, m_pend;
  int m_p, m_bq;
  logic [6:0] m_act [4];
  logic [6:0] m_sh [4];
  always #5 clk = ~clk;
  seg7_scan_driver #(.PRESCALE(P), .GAP(G)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load),
    .digit1(dg[0]), .digit2(dg[1]), .digit3(dg[2]), .digit4(dg[3]),
`ifdef SEG7_DIM_EN
    .bright(bright),
`endif
    .seg(seg), .an(an), .frame_done(frame_done), .pending(pending)
  );
  function automatic logic [12:0] obs();
    return {an, seg, frame_done, pending};
  endfunction
  function automatic logic [12:0] exp_out();
    logic [3:0] a = 4'hF;
    logic [6:0] s = 7'h7F;
    logic fd = 1'b0;
    int off, slot;
    if (m_run) begin
      off = m_p % S;
      slot = (m_p / S) % 4;
      fd = (m_p % FR) == FR - 1;
      if (off >= G) begin
        a = ~(4'b1000 >> slot);
        s = (off - G) < (m_bq + 1) * (P / 4) ? m_act[slot] : 7'h7F;
      end
    end
    return {a, s, fd, m_pend};
  endfunction
  task automatic model_reset();
    m_run = 0; m_p = 0; m_pend = 0; m_bq = 3;
    for (int i = 0; i < 4; i++) begin m_act[i] = 7'h7F; m_sh[i] = 7'h7F; end
  endtask
  task automatic model_step();
    bit bnd = m_run && en && (m_p % FR == FR - 1);
    if (load && !m_run) begin m_act = dg; m_pend = 0; end
    else if (bnd) begin
      if (load) m_act = dg;
      else if (m_pend) m_act = m_sh;
      m_pend = 0;
    end else if (load) begin m_sh = dg; m_pend = 1; end
    if (!en) m_run = 0;
    else if (!m_run) begin m_run = 1; m_p = 0; end
    else m_p++;
    if (m_run && m_p % S == G) m_bq = int'(bright);
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask
  task automatic test_reset();
    model_reset();
    #12;
    checks++;
    if (obs() !== {4'hF, 7'h7F, 1'b0, 1'b0}) $display("FAIL reset obs=%h exp=%h", obs(), {4'hF, 7'h7F, 2'b00});
    else passed++;
    @(negedge clk) rst_n = 1'b1;
  endtask
  task automatic test_scan();
    int fds = 0;
    dg = '{7'h7E, 7'h30, 7'h6D, 7'h79};
    load = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if (obs() !== {4'hF, 7'h7F, 1'b0, 1'b0}) $display("FAIL idle_load obs=%h exp=%h", obs(), {4'hF, 7'h7F, 2'b00});
    else passed++;
    en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick();
      fds += int'(frame_done);
      checks++;
      if (obs() !== exp_out()) $display("FAIL scan cyc=%0d obs=%h exp=%h", i, obs(), exp_out());
      else passed++;
      if (i == 2 || i == 12) begin
        checks++;
        if ({an, seg} !== (i == 2 ? {4'b0111, 7'h7E} : {4'b1011, 7'h30})) $display("FAIL scan_digit cyc=%0d obs=%h", i, {an, seg});
        else passed++;
      end
    end
    checks++;
    if (fds !== 2) $display("FAIL frame_count obs=%0d exp=2", fds);
    else passed++;
  endtask
  task automatic test_midload();
    for (int i = 0; i < 2 * FR && !(m_run && m_p % FR == S + G); i++) begin
      tick();
      checks++;
      if (obs() !== exp_out()) $display("FAIL mid_wait obs=%h exp=%h", obs(), exp_out());
      else passed++;
    end
    for (int i = 0; i < 4; i++) dg[i] = 7'($urandom);
    load = 1'b1;
    tick();
    dg = '{7'h08, 7'h08, 7'h08, 7'h08};
    tick();
    load = 1'b0;
    checks++;
    if (pending !== 1'b1) $display("FAIL mid_pending obs=%b exp=1", pending);
    else passed++;
    for (int i = 0; i < 2 * FR && !(m_p % FR == G); i++) begin
      tick();
      checks++;
      if (obs() !== exp_out()) $display("FAIL mid_run obs=%h exp=%h", obs(), exp_out());
      else passed++;
    end
    checks++;
    if ({an, seg, pending} !== {4'b0111, 7'h08, 1'b0}) $display("FAIL mid_apply obs=%h exp=%h", {an, seg, pending}, {4'b0111, 7'h08, 1'b0});
    else passed++;
  endtask
  task automatic test_boundary_load();
    logic [6:0] first;
    for (int i = 0; i < 2 * FR && !(m_run && m_p % FR == FR - 1); i++) begin
      tick();
      checks++;
      if (obs() !== exp_out()) $display("FAIL bnd_wait obs=%h exp=%h", obs(), exp_out());
      else passed++;
    end
    checks++;
    if (frame_done !== 1'b1) $display("FAIL bnd_fd obs=%b exp=1", frame_done);
    else passed++;
    for (int i = 0; i < 4; i++) dg[i] = 7'($urandom);
    first = dg[0];
    load = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if (pending !== 1'b0) $display("FAIL bnd_pending obs=%b exp=0", pending);
    else passed++;
    for (int i = 0; i < G; i++) tick();
    checks++;
    if ({an, seg} !== {4'b0111, first}) $display("FAIL bnd_apply obs=%h exp=%h", {an, seg}, {4'b0111, first});
    else passed++;
  endtask
  task automatic test_en_drop();
    for (int i = 0; i < 2 * FR && !(m_run && m_p % FR == 2 * S + G + 3); i++) tick();
    en = 1'b0;
    tick();
    checks++;
    if ({an, seg} !== {4'hF, 7'h7F}) $display("FAIL en_drop obs=%h exp=%h", {an, seg}, {4'hF, 7'h7F});
    else passed++;
    repeat (3) tick();
    en = 1'b1;
    for (int i = 0; i <= G; i++) begin
      tick();
      checks++;
      if (obs() !== exp_out()) $display("FAIL en_restart obs=%h exp=%h", obs(), exp_out());
      else passed++;
    end
    checks++;
    if (an !== 4'b0111) $display("FAIL en_digit1 obs=%b exp=0111", an);
    else passed++;
  endtask
  task automatic test_async_reset();
    for (int i = 0; i < 2 * FR && !(m_run && m_p % FR == S + G + 2); i++) tick();
    load = 1'b1;
    tick();
    load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs() !== {4'hF, 7'h7F, 1'b0, 1'b0}) $display("FAIL async_rst obs=%h exp=%h", obs(), {4'hF, 7'h7F, 2'b00});
    else passed++;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 2 * S; i++) begin
      tick();
      checks++;
      if (obs() !== exp_out()) $display("FAIL post_rst obs=%h exp=%h", obs(), exp_out());
      else passed++;
      if (i == G) begin
        checks++;
        if ({an, seg} !== {4'b0111, 7'h7F}) $display("FAIL post_rst_blank obs=%h exp=%h", {an, seg}, {4'b0111, 7'h7F});
        else passed++;
      end
    end
  endtask
`ifdef SEG7_DIM_EN
  task automatic test_dim();
    bright = 2'd1;
    dg = '{7'h01, 7'h02, 7'h04, 7'h10};
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 2 * FR; i++) begin
      tick();
      checks++;
      if (obs() !== exp_out()) $display("FAIL dim obs=%h exp=%h", obs(), exp_out());
      else passed++;
    end
  endtask
`endif
  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      en = $urandom_range(0, 29) != 0;
      load = $urandom_range(0, 9) == 0;
      for (int k = 0; k < 4; k++) dg[k] = 7'($urandom);
`ifdef SEG7_DIM_EN
      bright = 2'($urandom);
`endif
      tick();
      checks++;
      if (obs() !== exp_out()) $display("FAIL random cyc=%0d obs=%h exp=%h", i, obs(), exp_out());
      else passed++;
    end
    load = 1'b0;
    en = 1'b1;
  endtask
  initial begin
    dg = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};
    test_reset();
    test_scan();
    test_midload();
    test_boundary_load();
    test_en_drop();
    test_async_reset();
`ifdef SEG7_DIM_EN
    test_dim();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed scan driver for the 4-digit common-anode seven-segment display. It consumes active-low 7-bit segment patterns from the hex-digit and opcode display decoders and drives the shared cathode bus and per-digit anodes. A blanking gap between digits prevents ghosting. A double-buffered load applies new patterns only at frame boundaries, so the display never shows a torn mixture of old and new text.

## Interface
- PRESCALE, 50000, cycles each digit is lit per slot; must be ≥4 and a multiple of 4
- GAP, 64, blank cycles before each digit's lit phase; 0 allowed, meaning no gap phase
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable; low = display dark
- load  in  1  one-cycle strobe; captures digit1..digit4
- digit1  in  7  leftmost pattern, active-low, bit order {g,f,e,d,c,b,a}
- digit2, digit3  in  7  middle patterns
- digit4  in  7  rightmost pattern
- seg  out  7  cathode bus, active-low, registered
- an  out  4  anodes, active-low, registered; an[3] = digit1 … an[0] = digit4
- frame_done  out  1  one-cycle pulse at the end of digit4's lit phase
- pending  out  1  shadow loaded, not yet applied

## Operation
- **Reset values:** an=4'b1111, seg=7'h7F, frame_done=0, pending=0. Active and shadow registers = 7'h7F (blank). Index=0. State IDLE.
- **States:**
  - IDLE: outputs blank.
  - GAP: an=1111, seg=7F for GAP cycles.
  - ON: an[3-idx]=0, seg=active[idx] for PRESCALE cycles.
- **Transitions:**
  - IDLE→GAP when en=1 (→ON directly if GAP=0), idx=0.
  - GAP→ON after GAP cycles.
  - ON→GAP (or ON if GAP=0) after PRESCALE cycles, with idx+1.
  - After idx=3 ON: idx wraps to 0, frame_done pulses, and any pending shadow is copied into active, clearing pending.
- **en deasserted in any state:** next cycle IDLE, idx=0, outputs blank. Shadow, active and pending are retained.
- **load while scanning:** shadow←digits, pending←1. A repeated load before the boundary overwrites the shadow; only the latest value is applied.
- **load on the frame-boundary cycle:** active←digit inputs directly, pending←0. The new data wins over the older shadow.
- **load in IDLE:** active←digits immediately, pending stays 0.
- Counters are sized with $clog2 of PRESCALE and GAP and wrap only via the state transitions. Free-running overflow is not permitted.

## Timing
- All outputs are registered.
- Cycle latency from en sampled high to the first anode low is 1+GAP.
- Frame period is 4·(GAP+PRESCALE) cycles.
- frame_done is high for exactly the cycle in which the state leaves digit4's ON phase.
- Patterns loaded mid-frame appear at the first digit1 ON phase after the next frame_done. They never appear mid-frame.
- Asynchronous reset mid-scan forces the reset values immediately, with no wait for a clock edge.
- At most one anode is low in any cycle. Anodes are never low during GAP or IDLE.

## Configuration
- **SEG7_DIM_EN defined:**
  - Adds input bright [1:0].
  - The ON phase is split into four quarters of PRESCALE/4 cycles each.
  - seg = active pattern for the first bright+1 quarters and 7'h7F for the rest; the anode stays asserted for the whole phase.
  - bright is sampled at the start of each ON phase.
- **SEG7_DIM_EN undefined:** no bright port; seg shows the pattern for the full ON phase (equivalent to bright=3).

## Test plan
- Params PRESCALE=8, GAP=2. Reset, then en=1 with digits {7E,30,6D,79} pre-loaded in IDLE → an sequence 1111×3 cycles, then 0111×8 with seg=7E, 1111×2, 1011×8 with seg=30, and so on. frame_done is high once every 40 cycles.
- Mid-frame load of {08,08,08,08} during digit2 → pending=1; digits 2–4 keep the old values; after frame_done, digit1 shows 08 and pending=0.
- load asserted exactly on the frame_done cycle → the new data shows on the next digit1, with no extra frame of delay; pending stays 0.
- en dropped during digit3 ON → next cycle an=1111, seg=7F. en re-raised → scan restarts at digit1 after GAP.
- rst_n pulsed low mid-ON → an=1111, seg=7F, pending=0 asynchronously. After release, active is blank (seg=7F during ON).
- With SEG7_DIM_EN and bright=1: each ON phase shows the pattern for 4 cycles, then 7F for 4 cycles, with the anode low throughout.
